// File: rtl/bus6502_pkg.sv
// Shared register map, STATUS bit positions and UART TX state encoding for 6502 bus targets.
package bus6502_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam int ST_FULL   = 0;
    localparam int ST_EMPTY  = 1;
    localparam int ST_BUSY   = 2;
    localparam int ST_OVF    = 3;
    localparam int ST_CNT_LO = 4;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Purpose: generic single-clock FIFO, power-of-2 depth, head word visible combinationally.
// Latency: a pushed word is at the head (pop_dat) the cycle after the push edge.
// Backpressure: push is taken when not full or when a pop happens at the same edge; else ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_en;
    logic             push_en;

    assign empty   = (count == '0);
    assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
    assign pop_en  = pop & ~empty;
    assign push_en = push & (~full | pop_en);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_en, pop_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge i_clk) begin
        if (push_en) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/bus_uart_tx.sv
// Purpose: 6502 bus target with DATA/STATUS/CTRL registers feeding an 8N1 serial transmitter.
// Latency: read data one edge after the address; DATA write at edge N puts the start bit out after N+1.
// Backpressure: none on the bus; a DATA write into a full FIFO is dropped and sets sticky overflow.
module bus_uart_tx
    import bus6502_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR  = 16'hD000,
    parameter int          CLK_DIV    = 16,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_addr,
    input  logic [7:0]  i_data,
    input  logic        i_we,
    output logic [7:0]  o_data,
    output logic        o_sel,
    output logic        o_tx,
    output logic        o_irq
);

    localparam int                DIV_W    = $clog2(CLK_DIV);
    localparam int                CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [15:0]     offset;
    logic            hit;
    logic            wr_data;
    logic            wr_status;
    logic            wr_ctrl;
    logic [7:0]      rd_val;
    logic [3:0]      cnt_field;
    logic [4:0]      cnt_ext;

    logic            fifo_pop;
    logic [7:0]      fifo_dat;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    logic            overflow;
    logic            irq_en;

    uart_tx_state_t  state, state_nxt;
    logic [DIV_W-1:0] div_cnt, div_nxt;
    logic [2:0]      bit_cnt, bit_nxt;
    logic [7:0]      shift, shift_nxt;
    logic            tx_nxt;
    logic            div_done;

    // Subtracting the base keeps the window decode correct for any 16-bit base.
    assign offset    = i_addr - BASE_ADDR;
    assign hit       = (offset[15:2] == 14'd0);
    assign wr_data   = hit & i_we & (offset[1:0] == REG_DATA);
    assign wr_status = hit & i_we & (offset[1:0] == REG_STATUS);
    assign wr_ctrl   = hit & i_we & (offset[1:0] == REG_CTRL);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .push     (wr_data),
        .push_dat (i_data),
        .pop      (fifo_pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // A depth-16 FIFO holding 16 bytes reports 15 in the 4-bit field.
    assign cnt_ext   = 5'(fifo_count);
    assign cnt_field = cnt_ext[4] ? 4'hF : cnt_ext[3:0];

    always_comb begin
        rd_val = 8'h00;
        case (offset[1:0])
            REG_STATUS: begin
                rd_val[7:ST_CNT_LO] = cnt_field;
                rd_val[ST_OVF]      = overflow;
                rd_val[ST_BUSY]     = (state != IDLE);
                rd_val[ST_EMPTY]    = fifo_empty;
                rd_val[ST_FULL]     = fifo_full;
            end
            REG_CTRL: rd_val[0] = irq_en;
            default:  rd_val = 8'h00;
        endcase
    end

    assign div_done = (div_cnt == DIV_LAST);

    always_comb begin
        state_nxt = state;
        div_nxt   = div_cnt + 1'b1;
        bit_nxt   = bit_cnt;
        shift_nxt = shift;
        fifo_pop  = 1'b0;
        case (state)
            IDLE: begin
                div_nxt = '0;
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_nxt = fifo_dat;
                    bit_nxt   = 3'd0;
                    state_nxt = START;
                end
            end
            START: begin
                if (div_done) begin
                    div_nxt   = '0;
                    bit_nxt   = 3'd0;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (div_done) begin
                    div_nxt = '0;
                    if (bit_cnt == 3'd7) begin
                        bit_nxt   = 3'd0;
                        state_nxt = STOP;
                    end else begin
                        shift_nxt = {1'b0, shift[7:1]};
                        bit_nxt   = bit_cnt + 3'd1;
                    end
                end
            end
            STOP: begin
                if (div_done) begin
                    div_nxt = '0;
                    bit_nxt = 3'd0;
                    // Chain straight into the next start bit so queued frames have no idle gap.
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        shift_nxt = fifo_dat;
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        tx_nxt = 1'b1;
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shift_nxt[0];
            default: tx_nxt = 1'b1;
        endcase
    end

    // o_tx is registered from the next-state decode: same timing as the state, no glitches.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= 3'd0;
            shift   <= 8'h00;
            o_tx    <= 1'b1;
        end else begin
            state   <= state_nxt;
            div_cnt <= div_nxt;
            bit_cnt <= bit_nxt;
            shift   <= shift_nxt;
            o_tx    <= tx_nxt;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            overflow <= 1'b0;
            irq_en   <= 1'b0;
            o_irq    <= 1'b0;
            o_data   <= 8'h00;
            o_sel    <= 1'b0;
        end else begin
            if (wr_status && i_data[ST_OVF]) begin
                overflow <= 1'b0;
            end else if (wr_data && fifo_full && !fifo_pop) begin
                overflow <= 1'b1;
            end
            if (wr_ctrl) irq_en <= i_data[0];
            o_irq <= irq_en & fifo_empty & (state == IDLE);
            if (hit && !i_we) begin
                o_sel  <= 1'b1;
                o_data <= rd_val;
            end else begin
                o_sel  <= 1'b0;
                o_data <= 8'h00;
            end
        end
    end

endmodule
